terrain_ram_arbiter: RTL
========================

Name: terrain_ram_arbiter

Overview:
- Shares the single-port terrain RAM (1-bit grass/LFSR map) between two clients.
- Client 1 is the video readout, which has absolute priority during active draw.
- Client 2 is the gameplay terrain writer. Its writes are buffered in a small FIFO and drained into the RAM whenever the reader is idle (blanking).
- The block sits between the gameplay module, the pixel address generator and the RAM instance. Terrain can then be regenerated mid-game without tearing or gating the video.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 1, RAM data width.
- FIFO_DEPTH, 8, write-buffer entries; power of two, minimum 2.
- RAM_LATENCY, 2, RAM read latency in cycles (2 for HIGH_PERFORMANCE).

Ports:
- clk_in, input, 1. Pixel clock.
- rst_in, input, 1. Synchronous active-high reset.
- rd_active_in, input, 1. Reader owns the port this cycle (active-draw window).
- rd_addr_in, input, ADDR_W. Read address, sampled when rd_active_in=1.
- rd_valid_out, output, 1. rd_data_out corresponds to a read issued 1+RAM_LATENCY cycles earlier.
- rd_data_out, output, DATA_W. Read data.
- wr_valid_in, input, 1. Write request.
- wr_addr_in, input, ADDR_W. Write address.
- wr_data_in, input, DATA_W. Write data.
- wr_ready_out, output, 1. FIFO not full; a write is accepted when wr_valid_in && wr_ready_out.
- ram_addr_out, output, ADDR_W. Registered RAM address.
- ram_din_out, output, DATA_W. Registered RAM write data.
- ram_we_out, output, 1. Registered RAM write enable.
- ram_dout_in, input, DATA_W. RAM read data.
- fifo_count_out, output, clog2(FIFO_DEPTH)+1. Current buffered writes.
- overflow_out, output, 1. Sticky: a write was presented while full.
- busy_out, output, 1. FIFO non-empty or a drain write is in flight.

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_in is synchronous, active-high.
- Reset values: all outputs 0, except wr_ready_out=1. FIFO is emptied, the read-valid pipeline is cleared, state is S_IDLE.
- States are S_IDLE, S_READ and S_DRAIN, evaluated every cycle from the registered state and the inputs:
  - rd_active_in=1 -> S_READ, regardless of FIFO contents. The reader always wins.
  - rd_active_in=0 and FIFO non-empty -> S_DRAIN.
  - Otherwise -> S_IDLE.
- S_READ:
  - Next cycle: ram_addr_out<=rd_addr_in, ram_we_out<=0.
  - A 1 is pushed into a valid shift register of length 1+RAM_LATENCY.
  - rd_valid_out and rd_data_out (=ram_dout_in) appear exactly 3 cycles (default) after rd_addr_in is sampled.
  - One read per cycle, no bubbles.
- S_DRAIN:
  - Pop the FIFO head.
  - Next cycle: ram_addr_out/ram_din_out<=entry, ram_we_out<=1.
  - One write per cycle, in FIFO order.
- S_IDLE: ram_we_out<=0; ram_addr_out holds its value.
- The FIFO accepts pushes in every state.
  - Push and pop in the same cycle is legal; the count is unchanged.
  - An empty FIFO never bypasses; minimum write latency is 2 cycles from acceptance to ram_we_out.
- Full FIFO:
  - wr_ready_out=0.
  - A write presented while full is dropped, and overflow_out is set to 1 and held until reset.
- Simultaneous rd_active_in rise and pending drain: the read is issued and the pop is suppressed that cycle. No entry is lost or duplicated.
- rd_active_in fall: draining may begin the very next cycle.
- Reset mid-drain: pending writes are discarded, and ram_we_out=0 on the cycle after reset.
- rd_valid_out is 0 for any slot not issued in S_READ. rd_data_out is don't-care when rd_valid_out=0.

Optional Feature:
- Macro TERRAIN_ARB_STATS_EN.
- Defined:
  - Adds output stall_count_out[15:0], a saturating count of cycles in which the FIFO was non-empty but the reader held the port. It saturates at 16'hFFFF.
  - Adds input stats_clr_in, a synchronous clear. When clear and increment coincide, the clear wins.
- Undefined: neither port exists and no counter logic is synthesized.

Decomposition:
- Package terrain_arb_pkg: state enum arb_state_t {S_IDLE,S_READ,S_DRAIN}, default ADDR_W/DATA_W localparams, and typedef wr_entry_t (packed addr+data).
- Sub-module write_fifo: synchronous FIFO of wr_entry_t, parameterised by depth, with push/pop/full/empty/count. The arbiter FSM, read-valid pipeline and stats live in terrain_ram_arbiter.

Test Plan:
- Read pipeline: preload RAM[5]=1, RAM[6]=0. Drive rd_active_in=1 with addresses 5,6 on consecutive cycles. Expect rd_valid_out=1 with data 1 then 0, three cycles after each issue, and ram_we_out=0 throughout.
- Drain during blanking: with rd_active_in=0, push writes (10,1),(11,1),(12,0). Expect ram_we_out pulses on consecutive cycles starting 2 cycles after the first push, in order. Then busy_out=0 and fifo_count_out=0.
- Priority:
  - Push 4 writes.
  - Raise rd_active_in one cycle after draining starts.
  - Expect exactly 1 write, then reads only while active.
  - Expect the remaining 3 writes in order after the fall.
  - No duplicates.
- Full/overflow: hold rd_active_in=1 and push 9 writes with FIFO_DEPTH=8. Expect wr_ready_out=0 after the 8th, the 9th dropped, overflow_out=1 sticky, and fifo_count_out=8.
- Reset mid-drain: assert rst_in with 5 queued entries. Next cycle expect ram_we_out=0, fifo_count_out=0, wr_ready_out=1, overflow_out=0, and no further writes.
- Stats (TERRAIN_ARB_STATS_EN): 1 queued write with rd_active_in=1 for 100 cycles gives stall_count_out=100. Pulsing stats_clr_in gives 0.

Source files
------------

// File: rtl/terrain_arb_pkg.sv
// Shared types for the terrain RAM arbiter: FSM states, default widths, write entry.
// Optional stall statistics are enabled with TERRAIN_ARB_STATS_EN.
package terrain_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/terrain_ram_arbiter_write_fifo.sv
// Synchronous write-buffer FIFO for the terrain arbiter (no bypass path).
// Full pushes and empty pops are ignored internally.
module write_fifo
    import terrain_arb_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = wr_entry_t,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  T              i_data,
    input  logic          i_pop,
    output T              o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_head  = r_mem[r_rp];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wp] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/terrain_ram_arbiter.sv
// Single-port terrain RAM arbiter: video reads win, buffered gameplay writes drain in blanking.
// Define TERRAIN_ARB_STATS_EN to add stats_clr_in / stall_count_out.
module terrain_ram_arbiter
    import terrain_arb_pkg::*;
#(
    parameter int  ADDR_W      = ADDR_W_DEF,
    parameter int  DATA_W      = DATA_W_DEF,
    parameter int  FIFO_DEPTH  = 8,
    parameter int  RAM_LATENCY = 2,
    localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
`ifdef TERRAIN_ARB_STATS_EN
    input  logic              stats_clr_in,
    output logic [15:0]       stall_count_out,
`endif
    input  logic              rd_active_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    output logic              rd_valid_out,
    output logic [DATA_W-1:0] rd_data_out,
    input  logic              wr_valid_in,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [DATA_W-1:0] wr_data_in,
    output logic              wr_ready_out,
    output logic [ADDR_W-1:0] ram_addr_out,
    output logic [DATA_W-1:0] ram_din_out,
    output logic              ram_we_out,
    input  logic [DATA_W-1:0] ram_dout_in,
    output logic [CW-1:0]     fifo_count_out,
    output logic              overflow_out,
    output logic              busy_out
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic               w_pop;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    entry_t             w_head;
    entry_t             w_wr_entry;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic [DATA_W-1:0]  r_ram_din;
    logic               r_ram_we;
    logic [RAM_LATENCY:0] r_vld;
    logic               r_ovf;

    assign w_wr_entry = '{addr: wr_addr_in, data: wr_data_in};

    write_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .i_clk   (clk_in),
        .i_rst   (rst_in),
        .i_push  (wr_valid_in),
        .i_data  (w_wr_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (fifo_count_out)
    );

    // Reader always wins; a pending drain simply waits a cycle.
    always_comb begin
        w_state_nxt = S_IDLE;
        w_pop       = 1'b0;
        if (rd_active_in) begin
            w_state_nxt = S_READ;
        end else if (!w_fifo_empty) begin
            w_state_nxt = S_DRAIN;
            w_pop       = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_ram_we   <= 1'b0;
            r_vld      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_vld <= {r_vld[RAM_LATENCY-1:0], w_state_nxt == S_READ};
            unique case (w_state_nxt)
                S_READ: begin
                    r_ram_addr <= rd_addr_in;
                    r_ram_we   <= 1'b0;
                end
                S_DRAIN: begin
                    r_ram_addr <= w_head.addr;
                    r_ram_din  <= w_head.data;
                    r_ram_we   <= 1'b1;
                end
                default: begin
                    r_ram_we <= 1'b0;
                end
            endcase
            if (wr_valid_in && w_fifo_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

`ifdef TERRAIN_ARB_STATS_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk_in) begin
        if (rst_in || stats_clr_in) begin
            r_stall <= '0;
        end else if (rd_active_in && !w_fifo_empty && r_stall != 16'hFFFF) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign stall_count_out = r_stall;
`endif

    assign ram_addr_out = r_ram_addr;
    assign ram_din_out  = r_ram_din;
    assign ram_we_out   = r_ram_we;
    assign rd_valid_out = r_vld[RAM_LATENCY];
    assign rd_data_out  = ram_dout_in;
    assign wr_ready_out = !w_fifo_full;
    assign overflow_out = r_ovf;
    assign busy_out     = !w_fifo_empty || (r_state == S_DRAIN);

endmodule
